// File: rtl/binary_mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter slice.
//   N_DEF / W_DEF / LATENCY_DEF : default requester count, operand width and
//                                 multiplier latency (enabled cycles).
//   ID_MAX_W                    : id field width in a tag, enough for N <= 8.
//   tag_t                       : per-stage tag {valid, id, ovf} that travels
//                                 alongside the product through the pipeline.
package binary_mul_arbiter_pkg;

  localparam int N_DEF       = 4;
  localparam int W_DEF       = 10;
  localparam int LATENCY_DEF = 11;
  localparam int ID_MAX_W    = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic                ovf;
  } tag_t;

endpackage

// File: rtl/binary_mul_arbiter_if.sv
// Request/response bundle between operand producers, the arbiter and the
// consumer of products.
//   req_valid[N], req_a/req_b[N*W] (requester i at [i*W +: W]), req_ready[N]
//   rsp_valid, rsp_ready, rsp_id[IDW], rsp_p[2W-1], rsp_ovf, busy
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A source keeps valid and its payload stable until it transfers and
// never gates valid on ready; ready may depend combinationally on valid.
// The arbiter holds rsp_* stable while rsp_valid && !rsp_ready.
// Modport master = producer/consumer side, slave = arbiter side.
interface binary_mul_arbiter_if #(
  parameter int N   = 4,
  parameter int W   = 10,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [2*W-2:0] rsp_p;
  logic           rsp_ovf;
  logic           busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, rsp_ovf, busy
  );
endinterface

// File: rtl/binary_mul_arb_rr.sv
// N-way round-robin picker, purely combinational.
//   req[N] : request vector
//   ptr    : highest-priority index this cycle (0..N-1)
//   en     : when low no grant is issued
//   gnt[N] : one-hot grant (all zero when nothing granted)
//   idx    : index of the granted requester (0 when none)
//   any    : a grant was issued
module binary_mul_arb_rr #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Scan ptr, ptr+1, ... wrapping at N; first active request wins.
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/binary_mul_arbiter.sv
// Shares one pipelined signed multiplier among N requesters.
// One operand pair is granted per cycle in round-robin order; a tag pipeline
// carries {valid, id, ovf} alongside the product so results leave in accept
// order with their requester id. A response held by the consumer stalls the
// multiplier and the tag pipe as one unit.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : binary_mul_arbiter_if.slave (request and response channels)
// Optional (macro MUL_ARB_STATS_EN):
//   grant_cnt[N*16] : per-requester accepted count, wraps
//   stall_cnt[16]   : cycles with a stalled response, saturates
module binary_mul_arbiter
  import binary_mul_arbiter_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input logic clk,
  input logic rst_n,
  binary_mul_arbiter_if.slave bus
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [N*16-1:0] grant_cnt,
  output logic [15:0]     stall_cnt
`endif
);

  // Most negative operand; its square is the only product that does not fit
  // in 2W-1 bits, and it is replaced by the largest positive value.
  localparam logic [W-1:0]   OP_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [2*W-2:0] P_SAT  = {1'b0, {(2*W-2){1'b1}}};

  logic                  stall;
  logic                  adv;
  logic [IDW-1:0]        ptr_q;
  logic [N-1:0]          gnt;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_any;
  logic signed [W-1:0]   a_sel;
  logic signed [W-1:0]   b_sel;
  logic [2*W-2:0]        prod_in;
  tag_t                  tag_in;
  tag_t                  tag_q [LATENCY];
  logic [2*W-2:0]        p_q   [LATENCY];

  assign stall = tag_q[LATENCY-1].valid && !bus.rsp_ready;
  assign adv   = !stall;

  // Gating with rst_n keeps req_ready low for the whole reset cycle.
  binary_mul_arb_rr #(.N(N), .IDW(IDW)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .en  (adv && rst_n),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign bus.req_ready = gnt;

  // Operand mux: zero operands when nothing is granted (bubble).
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        a_sel = bus.req_a[i*W +: W];
        b_sel = bus.req_b[i*W +: W];
      end
    end
  end

  // Truncation to 2W-1 bits is exact for every pair except OP_MIN*OP_MIN.
  assign prod_in = a_sel * b_sel;

  always_comb begin
    tag_in            = '0;
    tag_in.valid      = gnt_any;
    tag_in.id[IDW-1:0] = gnt_idx;
    tag_in.ovf        = gnt_any && (a_sel == OP_MIN) && (b_sel == OP_MIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= '0;
        p_q[s]   <= '0;
      end
    end else if (adv) begin
      tag_q[0] <= tag_in;
      p_q[0]   <= prod_in;
      for (int s = 1; s < LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
        p_q[s]   <= p_q[s-1];
      end
      if (gnt_any) ptr_q <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign bus.rsp_valid = tag_q[LATENCY-1].valid;
  assign bus.rsp_id    = tag_q[LATENCY-1].id[IDW-1:0];
  assign bus.rsp_ovf   = tag_q[LATENCY-1].ovf;
  assign bus.rsp_p     = tag_q[LATENCY-1].ovf ? P_SAT : p_q[LATENCY-1];

  always_comb begin
    bus.busy = 1'b0;
    for (int s = 0; s < LATENCY; s++) bus.busy = bus.busy | tag_q[s].valid;
  end

`ifdef MUL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_binary_mul_arbiter.sv
// Directed and randomised bench for binary_mul_arbiter (N=4, W=10, LATENCY=11).
// Honors MUL_ARB_STATS_EN for port hookup.
module tb_binary_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 10;
  localparam int IDW = 2;
  localparam int LAT = 11;
  localparam int EW  = IDW + 2*W;   // {id, p[2W-2:0], ovf}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  binary_mul_arbiter_if #(.N(N), .W(W), .IDW(IDW)) bus ();

`ifdef MUL_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  binary_mul_arbiter #(.N(N), .W(W), .LATENCY(LAT), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MUL_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_total = 0;
  logic stall_prev = 1'b0;
  logic [EW-1:0] snap;

  logic [EW-1:0] exp_q[$];
  int            acc_cyc_q[$];
  int            acc_st_q[$];
  int            gnt_log[$];
  int            lat_log[$];
  logic [EW-1:0] rsp_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    logic [31:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    if (sa == -512 && sb == -512) return {IDW'(id), 19'h3FFFF, 1'b1};
    return {IDW'(id), p[18:0], 1'b0};
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    lat_log.delete();
    rsp_log.delete();
  endtask

  // One clock: observe on the falling edge, return 1 time unit after the rise.
  task automatic tick();
    logic stall_now;
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    int ac;
    int ast;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      stall_prev = 1'b0;
    end else begin
      check("onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      stall_now = bus.rsp_valid && !bus.rsp_ready;
      if (stall_now) begin
        check("stall_req_ready", 32'(bus.req_ready), 32'd0);
        if (stall_prev) check("stall_hold", 32'({bus.rsp_id, bus.rsp_p, bus.rsp_ovf}), 32'(snap));
        snap = {bus.rsp_id, bus.rsp_p, bus.rsp_ovf};
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_q.push_back(model(i, bus.req_a[i*W +: W], bus.req_b[i*W +: W]));
          acc_cyc_q.push_back(cyc);
          acc_st_q.push_back(stall_total);
          gnt_log.push_back(i);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        got = {bus.rsp_id, bus.rsp_p, bus.rsp_ovf};
        rsp_log.push_back(got);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          ac  = acc_cyc_q.pop_front();
          ast = acc_st_q.pop_front();
          check("rsp_data", 32'(got), 32'(exp));
          check("rsp_latency", 32'(cyc - ac), 32'(LAT + stall_total - ast));
          lat_log.push_back(cyc - ac);
        end
      end
      if (stall_now) stall_total++;
      stall_prev = stall_now;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    acc_cyc_q.delete();
    acc_st_q.delete();
    clear_logs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_id",    32'(bus.rsp_id),    32'd0);
    check("rst_p",     32'(bus.rsp_p),     32'd0);
    check("rst_ovf",   32'(bus.rsp_ovf),   32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);

    // Single request: -3 * 7
    set_req(0, 10'h3FD, 10'd7);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    check("t1_busy", 32'(bus.busy), 32'd1);
    drain();
    check("t1_count", 32'(rsp_log.size()), 32'd1);
    check("t1_lat", 32'(lat_log[0]), 32'd11);
    check("t1_rsp", 32'(rsp_log[0]), 32'({2'd0, 19'h7FFEB, 1'b0}));

    // All four requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 10'(i + 1), 10'(10 + i));
    bus.req_valid = 4'b1111;
    repeat (12) tick();
    bus.req_valid = '0;
    drain();
    check("t2_count", 32'(rsp_log.size()), 32'd12);
    for (int k = 0; k < 12; k++) begin
      check("t2_grant", 32'(gnt_log[k]), 32'(k % 4));
      check("t2_rsp_id", 32'(rsp_log[k][EW-1 -: IDW]), 32'(k % 4));
    end

    // Overflow corner and largest exact negative product
    clear_logs();
    set_req(0, 10'h200, 10'h200);
    bus.req_valid = 4'b0001;
    tick();
    set_req(1, 10'd511, 10'h200);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    drain();
    check("t3_sat", 32'(rsp_log[0]), 32'({2'd0, 19'h3FFFF, 1'b1}));
    check("t3_neg", 32'(rsp_log[1]), 32'({2'd1, 19'h40200, 1'b0}));

    // Backpressure for five cycles on the first result
    clear_logs();
    set_req(0, 10'd12, 10'h3F0);
    set_req(1, 10'h311, 10'd77);
    set_req(2, 10'd255, 10'd255);
    bus.req_valid = 4'b0111;
    repeat (3) tick();
    bus.req_valid = '0;
    repeat (8) tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    repeat (5) tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    drain();
    check("t4_count", 32'(rsp_log.size()), 32'd3);
    check("t4_lat", 32'(lat_log[0]), 32'd16);

    // Reset with six results in flight
    clear_logs();
    bus.req_valid = 4'b1111;
    repeat (6) tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    acc_cyc_q.delete();
    acc_st_q.delete();
    clear_logs();
    check("t5_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    repeat (15) tick();
    check("t5_no_rsp", 32'(rsp_log.size()), 32'd0);
    bus.req_valid = 4'b0101;
    tick();
    bus.req_valid = '0;
    check("t5_first_grant", 32'(gnt_log[0]), 32'd0);
    drain();

    // Random operands, request patterns and backpressure
    clear_logs();
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i,
                ($urandom_range(0, 7) == 0) ? 10'h200 : 10'($urandom_range(0, 1023)),
                ($urandom_range(0, 7) == 0) ? 10'h200 : 10'($urandom_range(0, 1023)));
      end
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("t6_some_rsp", 32'(rsp_log.size() > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
